// File: rtl/rob_commit_if.sv
// Dispatch, finish and commit signal bundle of the reorder buffer.
// The slave side is the ROB; the master side is dispatch, execution units and ARF/rename.
interface rob_commit_if #(
  parameter int RRF_SEL = 6,
  parameter int REG_SEL = 5
);
  logic               stall_dp_i;
  logic [RRF_SEL-1:0] rrfptr_i;
  logic               dp1_valid_i, dp2_valid_i;
  logic               dp1_dst_en_i, dp2_dst_en_i;
  logic [REG_SEL-1:0] dp1_dstnum_i, dp2_dstnum_i;

  logic               fin_we_alu1_i, fin_we_alu2_i, fin_we_ldst_i, fin_we_mul_i, fin_we_branch_i;
  logic [RRF_SEL-1:0] fin_rrftag_alu1_i, fin_rrftag_alu2_i, fin_rrftag_ldst_i;
  logic [RRF_SEL-1:0] fin_rrftag_mul_i, fin_rrftag_branch_i;

  logic [1:0]         com_inst_num_o;
  logic               completed1_we_o, completed2_we_o;
  logic [REG_SEL-1:0] completed1_dstnum_o, completed2_dstnum_o;
  logic [RRF_SEL-1:0] completed1_rrftag_o, completed2_rrftag_o;
  logic [RRF_SEL-1:0] comptr_o;
  logic               rob_empty_o;

  modport slave (
    input  stall_dp_i, rrfptr_i, dp1_valid_i, dp2_valid_i, dp1_dst_en_i, dp2_dst_en_i,
           dp1_dstnum_i, dp2_dstnum_i,
           fin_we_alu1_i, fin_we_alu2_i, fin_we_ldst_i, fin_we_mul_i, fin_we_branch_i,
           fin_rrftag_alu1_i, fin_rrftag_alu2_i, fin_rrftag_ldst_i, fin_rrftag_mul_i,
           fin_rrftag_branch_i,
    output com_inst_num_o, completed1_we_o, completed2_we_o, completed1_dstnum_o,
           completed2_dstnum_o, completed1_rrftag_o, completed2_rrftag_o, comptr_o, rob_empty_o
  );

  modport master (
    output stall_dp_i, rrfptr_i, dp1_valid_i, dp2_valid_i, dp1_dst_en_i, dp2_dst_en_i,
           dp1_dstnum_i, dp2_dstnum_i,
           fin_we_alu1_i, fin_we_alu2_i, fin_we_ldst_i, fin_we_mul_i, fin_we_branch_i,
           fin_rrftag_alu1_i, fin_rrftag_alu2_i, fin_rrftag_ldst_i, fin_rrftag_mul_i,
           fin_rrftag_branch_i,
    input  com_inst_num_o, completed1_we_o, completed2_we_o, completed1_dstnum_o,
           completed2_dstnum_o, completed1_rrftag_o, completed2_rrftag_o, comptr_o, rob_empty_o
  );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order retirement engine: one entry per RRF tag, up to two retirements per cycle
// from the head, with same-register kill so only the younger write reaches the ARF.
module rob_entry #(
  parameter int REG_SEL = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               dp_we_i,
  input  logic               dp_dst_en_i,
  input  logic [REG_SEL-1:0] dp_dstnum_i,
  input  logic               fin_i,
  input  logic               ret_i,
  output logic               valid_o,
  output logic               finished_o,
  output logic               dst_en_o,
  output logic [REG_SEL-1:0] dstnum_o
);
  logic               valid_q, valid_d, fin_q, fin_d, dst_en_q, dst_en_d;
  logic [REG_SEL-1:0] dstnum_q, dstnum_d;

  // Dispatch into a retiring entry never happens; dispatch is applied last anyway.
  always_comb begin
    valid_d  = valid_q;
    fin_d    = fin_q;
    dst_en_d = dst_en_q;
    dstnum_d = dstnum_q;
    if (fin_i && valid_q) fin_d = 1'b1;
    if (ret_i) begin
      valid_d = 1'b0;
      fin_d   = 1'b0;
    end
    if (dp_we_i) begin
      valid_d  = 1'b1;
      fin_d    = 1'b0;
      dst_en_d = dp_dst_en_i;
      dstnum_d = dp_dstnum_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q  <= 1'b0;
      fin_q    <= 1'b0;
      dst_en_q <= 1'b0;
      dstnum_q <= '0;
    end else begin
      valid_q  <= valid_d;
      fin_q    <= fin_d;
      dst_en_q <= dst_en_d;
      dstnum_q <= dstnum_d;
    end
  end

  assign valid_o    = valid_q;
  assign finished_o = fin_q;
  assign dst_en_o   = dst_en_q;
  assign dstnum_o   = dstnum_q;
endmodule

module rob_commit_unit #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6,
  parameter int REG_SEL = 5
) (
  input  logic          clk_i,
  input  logic          reset_i,
  rob_commit_if.slave   bus
);
  localparam int FU = 5;

  logic [FU-1:0]                  fin_we;
  logic [FU-1:0][RRF_SEL-1:0]     fin_tag;
  logic [RRF_NUM-1:0]             valid, finished, dst_en;
  logic [RRF_NUM-1:0][REG_SEL-1:0] dstnum;
  logic [RRF_SEL-1:0]             dp2_ptr, head1, head2;
  logic [RRF_SEL-1:0]             comptr_q, comptr_d;
  logic                           c1, c2, kill;
  logic [1:0]                     com_num;

  assign fin_we  = {bus.fin_we_branch_i, bus.fin_we_mul_i, bus.fin_we_ldst_i,
                    bus.fin_we_alu2_i, bus.fin_we_alu1_i};
  assign fin_tag = {bus.fin_rrftag_branch_i, bus.fin_rrftag_mul_i, bus.fin_rrftag_ldst_i,
                    bus.fin_rrftag_alu2_i, bus.fin_rrftag_alu1_i};

  assign dp2_ptr = bus.rrfptr_i + 1'b1;
  assign head1   = comptr_q;
  assign head2   = comptr_q + 1'b1;

  assign c1      = valid[head1] & finished[head1];
  assign c2      = c1 & valid[head2] & finished[head2];
  assign kill    = c2 & dst_en[head1] & dst_en[head2] & (dstnum[head1] == dstnum[head2]);
  assign com_num = {1'b0, c1} + {1'b0, c2};

  for (genvar i = 0; i < RRF_NUM; i++) begin : g_ent
    localparam logic [RRF_SEL-1:0] TAG = RRF_SEL'(i);
    logic          hit1, hit2, dp_we, fin, ret;
    logic [FU-1:0] fu_hit;

    for (genvar u = 0; u < FU; u++) begin : g_fu
      assign fu_hit[u] = fin_we[u] && (fin_tag[u] == TAG);
    end

    assign hit1  = bus.dp1_valid_i && (bus.rrfptr_i == TAG);
    assign hit2  = bus.dp2_valid_i && (dp2_ptr == TAG);
    assign dp_we = !bus.stall_dp_i && (hit1 || hit2);
    assign fin   = |fu_hit;
    assign ret   = (c1 && (head1 == TAG)) || (c2 && (head2 == TAG));

    rob_entry #(.REG_SEL(REG_SEL)) u_ent (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .dp_we_i     (dp_we),
      .dp_dst_en_i (hit2 ? bus.dp2_dst_en_i : bus.dp1_dst_en_i),
      .dp_dstnum_i (hit2 ? bus.dp2_dstnum_i : bus.dp1_dstnum_i),
      .fin_i       (fin),
      .ret_i       (ret),
      .valid_o     (valid[i]),
      .finished_o  (finished[i]),
      .dst_en_o    (dst_en[i]),
      .dstnum_o    (dstnum[i])
    );
  end

  assign comptr_d = comptr_q + RRF_SEL'(com_num);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) comptr_q <= '0;
    else         comptr_q <= comptr_d;
  end

  // Idle commit slots drive zero so the bus is quiet when nothing retires.
  assign bus.com_inst_num_o      = com_num;
  assign bus.completed1_we_o     = c1 & dst_en[head1] & ~kill;
  assign bus.completed2_we_o     = c2 & dst_en[head2];
  assign bus.completed1_dstnum_o = c1 ? dstnum[head1] : '0;
  assign bus.completed2_dstnum_o = c2 ? dstnum[head2] : '0;
  assign bus.completed1_rrftag_o = c1 ? head1 : '0;
  assign bus.completed2_rrftag_o = c2 ? head2 : '0;
  assign bus.comptr_o            = comptr_q;
  assign bus.rob_empty_o         = ~|valid;
endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: dispatch, finish, dual commit, kill, wrap, reset.
module tb_rob_commit_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rob_commit_if #(.RRF_SEL(6), .REG_SEL(5)) bus ();

  rob_commit_unit #(.RRF_NUM(64), .RRF_SEL(6), .REG_SEL(5)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall_dp_i   = 1'b0;
    bus.rrfptr_i     = '0;
    bus.dp1_valid_i  = 1'b0; bus.dp2_valid_i  = 1'b0;
    bus.dp1_dst_en_i = 1'b0; bus.dp2_dst_en_i = 1'b0;
    bus.dp1_dstnum_i = '0;   bus.dp2_dstnum_i = '0;
    bus.fin_we_alu1_i = 1'b0; bus.fin_we_alu2_i = 1'b0; bus.fin_we_ldst_i = 1'b0;
    bus.fin_we_mul_i  = 1'b0; bus.fin_we_branch_i = 1'b0;
    bus.fin_rrftag_alu1_i = '0; bus.fin_rrftag_alu2_i = '0; bus.fin_rrftag_ldst_i = '0;
    bus.fin_rrftag_mul_i  = '0; bus.fin_rrftag_branch_i = '0;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input int p, input bit v1, input bit e1, input int n1,
                      input bit v2, input bit e2, input int n2);
    bus.rrfptr_i     = 6'(p);
    bus.dp1_valid_i  = v1; bus.dp1_dst_en_i = e1; bus.dp1_dstnum_i = 5'(n1);
    bus.dp2_valid_i  = v2; bus.dp2_dst_en_i = e2; bus.dp2_dstnum_i = 5'(n2);
  endtask

  // unit: 0 alu1, 1 alu2, 2 ldst, 3 mul, 4 branch
  task automatic fin(input int unit, input int tag);
    case (unit)
      0: begin bus.fin_we_alu1_i   = 1'b1; bus.fin_rrftag_alu1_i   = 6'(tag); end
      1: begin bus.fin_we_alu2_i   = 1'b1; bus.fin_rrftag_alu2_i   = 6'(tag); end
      2: begin bus.fin_we_ldst_i   = 1'b1; bus.fin_rrftag_ldst_i   = 6'(tag); end
      3: begin bus.fin_we_mul_i    = 1'b1; bus.fin_rrftag_mul_i    = 6'(tag); end
      default: begin bus.fin_we_branch_i = 1'b1; bus.fin_rrftag_branch_i = 6'(tag); end
    endcase
  endtask

  task automatic chk_com(input string tag, input int num, input int we1, input int d1,
                         input int t1, input int we2, input int d2, input int t2);
    chk({tag, ".num"}, 32'(bus.com_inst_num_o), num);
    chk({tag, ".we1"}, 32'(bus.completed1_we_o), we1);
    chk({tag, ".dst1"}, 32'(bus.completed1_dstnum_o), d1);
    chk({tag, ".tag1"}, 32'(bus.completed1_rrftag_o), t1);
    chk({tag, ".we2"}, 32'(bus.completed2_we_o), we2);
    chk({tag, ".dst2"}, 32'(bus.completed2_dstnum_o), d2);
    chk({tag, ".tag2"}, 32'(bus.completed2_rrftag_o), t2);
  endtask

  // Dispatch must never target an entry retiring at the same edge.
  always @(posedge clk) begin
    if (!rst && !bus.stall_dp_i) begin
      logic [5:0] r1, r2, d2;
      r1 = bus.comptr_o;
      r2 = bus.comptr_o + 6'd1;
      d2 = bus.rrfptr_i + 6'd1;
      assert (!(bus.dp1_valid_i && ((bus.com_inst_num_o >= 2'd1 && bus.rrfptr_i == r1) ||
                                    (bus.com_inst_num_o == 2'd2 && bus.rrfptr_i == r2))))
        else $error("dispatch slot 1 targets a retiring entry");
      assert (!(bus.dp2_valid_i && ((bus.com_inst_num_o >= 2'd1 && d2 == r1) ||
                                    (bus.com_inst_num_o == 2'd2 && d2 == r2))))
        else $error("dispatch slot 2 targets a retiring entry");
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.empty", 32'(bus.rob_empty_o), 1);
    chk("rst.comptr", 32'(bus.comptr_o), 0);
    chk_com("rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    go();

    // dual commit
    disp(0, 1, 1, 3, 1, 1, 4); go();
    chk("dual.pend_num", 32'(bus.com_inst_num_o), 0);
    chk("dual.pend_empty", 32'(bus.rob_empty_o), 0);
    fin(0, 0); fin(1, 1); go();
    chk_com("dual", 2, 1, 3, 0, 1, 4, 1);
    go();
    chk("dual.comptr", 32'(bus.comptr_o), 2);
    chk("dual.empty", 32'(bus.rob_empty_o), 1);

    // out-of-order finish of tags 2,3,4
    disp(2, 1, 1, 1, 1, 1, 2); go();
    disp(4, 1, 1, 9, 0, 0, 0); go();
    fin(2, 4); go();
    chk("ooo.t4_num", 32'(bus.com_inst_num_o), 0);
    fin(1, 3); fin(3, 3); go();
    chk("ooo.t3_num", 32'(bus.com_inst_num_o), 0);
    fin(4, 2); go();
    chk_com("ooo.pair", 2, 1, 1, 2, 1, 2, 3);
    go();
    chk("ooo.comptr4", 32'(bus.comptr_o), 4);
    chk_com("ooo.last", 1, 1, 9, 4, 0, 0, 0);
    go();
    chk("ooo.comptr5", 32'(bus.comptr_o), 5);
    chk("ooo.empty", 32'(bus.rob_empty_o), 1);

    // same-register kill
    disp(5, 1, 1, 7, 1, 1, 7); go();
    fin(2, 5); fin(3, 6); go();
    chk_com("kill", 2, 0, 7, 5, 1, 7, 6);
    go();
    chk("kill.comptr", 32'(bus.comptr_o), 7);

    // no destination, invalid finish, stalled dispatch
    disp(7, 1, 0, 12, 0, 0, 0); go();
    fin(4, 8); go();
    chk("nodst.pend_num", 32'(bus.com_inst_num_o), 0);
    fin(0, 7); go();
    chk_com("nodst", 1, 0, 12, 7, 0, 0, 0);
    go();
    chk("nodst.comptr", 32'(bus.comptr_o), 8);
    chk("inv.empty", 32'(bus.rob_empty_o), 1);
    bus.stall_dp_i = 1'b1;
    disp(8, 1, 1, 3, 1, 1, 3); go();
    chk("stall.empty", 32'(bus.rob_empty_o), 1);
    chk("stall.num", 32'(bus.com_inst_num_o), 0);

    // sustained two-per-cycle stream up to the wrap point
    for (int p = 8; p <= 60; p += 2) begin
      disp(p, 1, 1, p & 31, 1, 1, (p + 1) & 31);
      if (p > 8) begin fin(0, p - 2); fin(1, p - 1); end
      go();
      if (p >= 10) begin
        chk("stream.num", 32'(bus.com_inst_num_o), 2);
        chk("stream.comptr", 32'(bus.comptr_o), 32'(p - 2));
      end
    end
    disp(62, 1, 1, 2, 0, 0, 0); fin(0, 60); fin(1, 61); go();
    chk("tail.comptr60", 32'(bus.comptr_o), 60);
    fin(4, 62); go();
    chk("tail.comptr62", 32'(bus.comptr_o), 62);
    chk_com("tail", 1, 1, 2, 62, 0, 0, 0);
    go();
    chk("tail.comptr63", 32'(bus.comptr_o), 63);
    chk("tail.empty", 32'(bus.rob_empty_o), 1);

    // wrap: dispatch at 63 puts slot 2 into entry 0
    disp(63, 1, 1, 5, 1, 1, 6); go();
    chk("wrap.pend_num", 32'(bus.com_inst_num_o), 0);
    chk("wrap.pend_empty", 32'(bus.rob_empty_o), 0);
    fin(0, 63); fin(4, 0); go();
    chk_com("wrap", 2, 1, 5, 63, 1, 6, 0);
    go();
    chk("wrap.comptr", 32'(bus.comptr_o), 1);
    chk("wrap.empty", 32'(bus.rob_empty_o), 1);

    // asynchronous reset with five entries in flight
    disp(1, 1, 1, 1, 1, 1, 2); go();
    disp(3, 1, 1, 3, 1, 1, 4); fin(0, 2); go();
    disp(5, 1, 1, 5, 0, 0, 0); fin(0, 3); go();
    fin(0, 1); go();
    chk_com("pre_rst", 2, 1, 1, 1, 1, 2, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst.empty", 32'(bus.rob_empty_o), 1);
    chk("arst.comptr", 32'(bus.comptr_o), 0);
    chk_com("arst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    go();
    chk("post_rst.empty", 32'(bus.rob_empty_o), 1);
    chk("post_rst.num", 32'(bus.com_inst_num_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
